ttl74259_serial_latch: RTL and testbench
========================================

Name: ttl74259_serial_latch

Overview:
- Clocked 8-bit addressable latch in the style of a 74259, with a bit-serial loader front end.
- It is the write-side counterpart of the 8:1 mux used for parallel-to-serial readout. Here, bits arrive one at a time and are steered into addressed latch positions.
- Typical uses: rebuilding a byte shifted out through a mux-and-counter path, or driving individual control lines from a 3-bit address plus a data bit.

Parameters:
- None. Width is fixed at 8 latches with a 3-bit address, matching the TTL part.

Ports:
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high reset
- addr  input  3  latch address for parallel operations
- data  input  1  data bit for parallel operations
- enable_n  input  1  active-low parallel write strobe
- clear_n  input  1  active-low clear/demux mode select
- ser_start  input  1  begins a serial load of 8 bits
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in is valid this cycle
- ser_ready  output  1  loader accepts a bit this cycle
- busy  output  1  serial load in progress
- done  output  1  one-cycle pulse after the 8th bit is accepted
- q  output  8  latch outputs; q[i] is latch i
- q_n  output  8  bitwise complement of q

Behaviour:
- All state is updated on the rising edge of clock; no asynchronous paths.
- q_n is always ~q, combinationally.

Reset (reset=1 at an edge):
- q=8'h00, FSM to IDLE, bit counter=0.
- ser_ready=0, busy=0, done=0.
- reset overrides every other input, including mid-load; any partial load is discarded and q is cleared.

Parallel modes (evaluated every edge while the FSM is IDLE or DONE):
- clear_n=1, enable_n=1: hold q.
- clear_n=1, enable_n=0: addressable latch. q[addr] <= data; other bits hold.
- clear_n=0, enable_n=1: clear. q <= 8'h00.
- clear_n=0, enable_n=0: demux. q <= 8'h00 with bit addr set to data (one-hot or all-zero).

FSM states:
- IDLE: ser_ready=0, busy=0.
  - ser_start=1 -> LOAD, counter <= 0.
  - If a parallel operation is asserted in the same cycle as ser_start, it still takes effect on that edge.
- LOAD: ser_ready=1, busy=1.
  - On an edge with ser_valid=1: q[counter] <= ser_in, counter <= counter+1.
  - Bit 0 is loaded first.
  - When the accepted bit has counter==7 -> DONE; counter wraps to 0.
  - ser_valid=0: hold, no timeout.
  - enable_n=0 is ignored in LOAD.
  - ser_start is ignored in LOAD.
- LOAD abort: clear_n=0 in LOAD clears q to 8'h00 and returns to IDLE; done is not pulsed.
  - This takes priority over a simultaneous ser_valid.
  - enable_n is ignored on this edge, so the demux mode does not apply.
- DONE: done=1, busy=0, ser_ready=0 for exactly one cycle.
  - Parallel modes are honoured.
  - Next state is LOAD if ser_start=1 (counter <= 0), else IDLE.

Latency and timing:
- Parallel write is visible on q the cycle after the edge.
- A full serial load takes a minimum of 9 edges from ser_start to the done pulse, i.e. start plus 8 accepted bits.
- ser_ready and busy are registered state decodes, not combinational on ser_valid.

Test Plan:
- Reset, then addressable writes addr=3 data=1 and addr=6 data=1, enable_n=0, clear_n=1 -> q=8'h48, q_n=8'hB7; next edge with enable_n=1 holds 8'h48.
- From q=8'hFF: clear_n=0 enable_n=0 addr=5 data=1 -> q=8'h20; repeat with data=0 -> q=8'h00; clear_n=0 enable_n=1 -> q=8'h00.
- ser_start, then 8 consecutive valid bits 1,0,1,1,0,0,1,0 (bit 0 first):
  - -> q=8'h4D.
  - ser_ready high for 8 cycles.
  - done high exactly one cycle after the 8th bit.
  - busy low in DONE.
- Serial load with ser_valid gaps (valid every 3rd cycle, byte 8'hA5) -> q=8'hA5 only after the 8th valid bit; enable_n=0 addr=0 data=0 during the load leaves bit 0 as loaded.
- Abort: start a load, accept 4 bits, then clear_n=0 -> q=8'h00, IDLE, no done pulse; a fresh load of 8'h3C then completes correctly with the counter restarted at 0.
- Reset asserted after 5 accepted bits -> q=8'h00, busy=0, ser_ready=0; back-to-back loads via ser_start in DONE (8'h11 then 8'hEE) -> q=8'hEE, two done pulses 8 accepts apart.

Source files
------------

// File: rtl/ttl74259_serial_latch.sv
// rtl/ttl74259_serial_latch.sv - 8-bit addressable latch (74259 style) with bit-serial loader
module ttl74259_serial_latch (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic       data,
    input  logic       enable_n,
    input  logic       clear_n,
    input  logic       ser_start,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic       ser_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [7:0] q_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] par_q;

    // Next latch value for the four parallel modes of the TTL part
    always_comb begin
        par_q = q;
        case ({clear_n, enable_n})
            2'b11: par_q = q;
            2'b10: par_q[addr] = data;
            2'b01: par_q = 8'h00;
            2'b00: begin
                par_q       = 8'h00;
                par_q[addr] = data;
            end
            default: par_q = q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            q         <= 8'h00;
            ser_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    // Clear aborts the load and wins over a bit arriving on the same edge
                    if (!clear_n) begin
                        q         <= 8'h00;
                        bit_cnt   <= 3'd0;
                        state     <= IDLE;
                        ser_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (ser_valid) begin
                        q[bit_cnt] <= ser_in;
                        bit_cnt    <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state     <= DONE;
                            ser_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    q <= par_q;
                    if (ser_start) begin
                        state     <= LOAD;
                        bit_cnt   <= 3'd0;
                        ser_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        ser_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_ttl74259_serial_latch.sv
// tb/tb_ttl74259_serial_latch.sv - directed self-checking bench for ttl74259_serial_latch
module tb_ttl74259_serial_latch;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] addr;
    logic       data;
    logic       enable_n;
    logic       clear_n;
    logic       ser_start;
    logic       ser_in;
    logic       ser_valid;
    logic       ser_ready;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] q_n;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_cnt;
    int done_seen;
    int done_cyc0;
    int done_cyc1;

    ttl74259_serial_latch dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .data      (data),
        .enable_n  (enable_n),
        .clear_n   (clear_n),
        .ser_start (ser_start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .q_n       (q_n)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feeds n bits of b (bit 0 first); gap idle cycles before each valid bit
    task automatic feed(input logic [7:0] b, input int n, input int gap,
                        output int rdy, output int dn);
        rdy = 0;
        dn  = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                ser_valid = 1'b0;
                if (ser_ready) rdy++;
                if (done) dn++;
                step();
            end
            ser_valid = 1'b1;
            ser_in    = b[i];
            if (ser_ready) rdy++;
            if (done) dn++;
            step();
        end
        ser_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 3'd0; data = 1'b0; enable_n = 1'b1; clear_n = 1'b1;
        ser_start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
        step();
        step();
        check("reset_q", q, 8'h00);
        check("reset_q_n", q_n, 8'hFF);
        check("reset_ready", ser_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        enable_n = 1'b0; addr = 3'd3; data = 1'b1; step();
        addr = 3'd6; step();
        enable_n = 1'b1;
        check("latch_q", q, 8'h48);
        check("latch_q_n", q_n, 8'hB7);
        step();
        check("hold_q", q, 8'h48);

        enable_n = 1'b0; data = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr = a[2:0];
            step();
        end
        check("all_ones", q, 8'hFF);
        clear_n = 1'b0; addr = 3'd5; data = 1'b1; step();
        check("demux_1", q, 8'h20);
        data = 1'b0; step();
        check("demux_0", q, 8'h00);
        clear_n = 1'b1; addr = 3'd2; data = 1'b1; step();
        check("latch_b2", q, 8'h04);
        clear_n = 1'b0; enable_n = 1'b1; step();
        check("clear", q, 8'h00);
        clear_n = 1'b1;

        ser_start = 1'b1; step();
        ser_start = 1'b0;
        check("start_ready", ser_ready, 1);
        check("start_busy", busy, 1);
        feed(8'h4D, 8, 0, rdy_cnt, done_seen);
        check("ser_q_4d", q, 8'h4D);
        check("ser_ready_cycles", rdy_cnt, 8);
        check("ser_no_early_done", done_seen, 0);
        check("ser_done", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", ser_ready, 0);
        step();
        check("done_one_cycle", done, 0);
        check("after_done_q", q, 8'h4D);

        ser_start = 1'b1; step();
        ser_start = 1'b0;
        feed(8'hA5, 1, 2, rdy_cnt, done_seen);
        enable_n = 1'b0; addr = 3'd0; data = 1'b0;
        feed(8'hA5 >> 1, 1, 2, rdy_cnt, done_seen);
        enable_n = 1'b1;
        check("gap_bit0_kept", q[0], 1);
        feed(8'hA5 >> 2, 5, 2, rdy_cnt, done_seen);
        check("gap_before_last", q, 8'h25);
        check("gap_not_done", done, 0);
        feed(8'hA5 >> 7, 1, 2, rdy_cnt, done_seen);
        check("gap_q_a5", q, 8'hA5);
        check("gap_done", done, 1);
        step();

        ser_start = 1'b1; step();
        ser_start = 1'b0;
        feed(8'hFF, 4, 0, rdy_cnt, done_seen);
        check("abort_partial", q, 8'hAF);
        clear_n = 1'b0; enable_n = 1'b0; addr = 3'd7; data = 1'b1;
        ser_valid = 1'b1; ser_in = 1'b1;
        step();
        clear_n = 1'b1; enable_n = 1'b1; ser_valid = 1'b0;
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_ready", ser_ready, 0);
        check("abort_no_done", done, 0);
        step();
        check("abort_no_done2", done, 0);
        ser_start = 1'b1; step();
        ser_start = 1'b0;
        feed(8'h3C, 8, 0, rdy_cnt, done_seen);
        check("reload_q_3c", q, 8'h3C);
        check("reload_done", done, 1);
        step();

        ser_start = 1'b1; step();
        ser_start = 1'b0;
        feed(8'hFF, 5, 0, rdy_cnt, done_seen);
        check("partial_5", q, 8'h3F);
        reset = 1'b1; step();
        reset = 1'b0;
        check("midreset_q", q, 8'h00);
        check("midreset_busy", busy, 0);
        check("midreset_ready", ser_ready, 0);

        ser_start = 1'b1; step();
        ser_start = 1'b0;
        feed(8'h11, 8, 0, rdy_cnt, done_seen);
        check("b2b_q_11", q, 8'h11);
        check("b2b_done0", done, 1);
        done_cyc0 = cyc;
        ser_start = 1'b1; step();
        ser_start = 1'b0;
        check("b2b_restart_ready", ser_ready, 1);
        check("b2b_restart_done", done, 0);
        feed(8'hEE, 8, 0, rdy_cnt, done_seen);
        done_cyc1 = cyc;
        check("b2b_q_ee", q, 8'hEE);
        check("b2b_done1", done, 1);
        check("b2b_no_extra_done", done_seen, 0);
        check("b2b_spacing", done_cyc1 - done_cyc0, 9);
        step();
        check("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
